// File: rtl/pulse_decoder_pkg.sv
// Shared encodings for the pulse decoder: width FSM, output handshake FSM
// and the data-bit codes produced by pulse-width classification.
package pulse_decoder_pkg;

  typedef enum logic {
    W_LOW  = 1'b0,
    W_HIGH = 1'b1
  } w_state_t;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_DAV  = 1'b1
  } o_state_t;

  localparam logic BIT_SHORT = 1'b0;
  localparam logic BIT_LONG  = 1'b1;

endpackage

// File: rtl/pulse_width_meter.sv
// Measures each high pulse on `in` with a saturating counter and classifies
// it as a short bit, a long bit or an invalid width on the falling-edge cycle.
module pulse_width_meter
  import pulse_decoder_pkg::*;
#(
  parameter int SHORT_LEN = 6,
  parameter int LONG_LEN  = 12,
  parameter int TOL       = 1,
  parameter int CNT_W     = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic bit_valid,
  output logic bit_value,
  output logic bit_err
);

  localparam logic [CNT_W-1:0] SHORT_MIN = CNT_W'(SHORT_LEN - TOL);
  localparam logic [CNT_W-1:0] SHORT_MAX = CNT_W'(SHORT_LEN + TOL);
  localparam logic [CNT_W-1:0] LONG_MIN  = CNT_W'(LONG_LEN - TOL);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_LEN + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  w_state_t         state;
  logic [CNT_W-1:0] cnt;
  logic             fall, is_short, is_long;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= W_LOW;
      cnt   <= '0;
    end else begin
      case (state)
        W_LOW: begin
          if (in) begin
            state <= W_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        W_HIGH: begin
          if (in) begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          end else begin
            state <= W_LOW;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Strobes are decoded from the current state and input so the top level
  // acts on the very edge that samples the falling input.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    fall      = 1'b0;
    is_short  = 1'b0;
    is_long   = 1'b0;
    bit_valid = 1'b0;
    bit_err   = 1'b0;
    bit_value = BIT_SHORT;
    fall      = (state == W_HIGH) && !in;
    is_short  = (cnt >= SHORT_MIN) && (cnt <= SHORT_MAX);
    is_long   = (cnt >= LONG_MIN) && (cnt <= LONG_MAX);
    bit_valid = fall && (is_short || is_long);
    bit_err   = fall && !(is_short || is_long);
    bit_value = is_long ? BIT_LONG : BIT_SHORT;
  end

endmodule

// File: rtl/pulse_decoder.sv
// Packs classified pulse widths MSB-first into words and hands each word to
// a consumer over the dav_/rfd handshake, flagging invalid widths and overruns.
module pulse_decoder
  import pulse_decoder_pkg::*;
#(
  parameter int SHORT_LEN = 6,
  parameter int LONG_LEN  = 12,
  parameter int TOL       = 1,
  parameter int CNT_W     = 5,
  parameter int BITS      = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in,
  input  logic            rfd,
  output logic            dav_,
  output logic [BITS-1:0] data,
  output logic            err,
  output logic            ovr
);

  localparam int BC_W = (BITS > 1) ? $clog2(BITS) : 1;

  logic            bit_valid, bit_value, bit_err;
  logic [BITS-1:0] shift, hold, word;
  logic [BC_W-1:0] bit_cnt;
  logic            hold_full, word_done, hold_clear;
  o_state_t        o_state;

  pulse_width_meter #(
    .SHORT_LEN(SHORT_LEN),
    .LONG_LEN (LONG_LEN),
    .TOL      (TOL),
    .CNT_W    (CNT_W)
  ) u_meter (
    .clock    (clock),
    .reset    (reset),
    .in       (in),
    .bit_valid(bit_valid),
    .bit_value(bit_value),
    .bit_err  (bit_err)
  );

  assign word       = {shift[BITS-2:0], bit_value};
  assign word_done  = bit_valid && (bit_cnt == BC_W'(BITS - 1));
  assign hold_clear = (o_state == O_DAV) && !rfd;

  always_ff @(posedge clock) begin
    if (reset) begin
      shift     <= '0;
      bit_cnt   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      data      <= '0;
      dav_      <= 1'b1;
      err       <= 1'b0;
      ovr       <= 1'b0;
      o_state   <= O_IDLE;
    end else begin
      err <= bit_err;

      // An invalid width drops the partial word so the next word starts clean.
      if (bit_err) begin
        shift   <= '0;
        bit_cnt <= '0;
      end else if (bit_valid) begin
        shift   <= word;
        bit_cnt <= word_done ? '0 : bit_cnt + BC_W'(1);
      end

      // A word landing on the edge that empties the hold is accepted, not lost.
      if (word_done) begin
        if (hold_full && !hold_clear) begin
          ovr <= 1'b1;
        end else begin
          hold      <= word;
          hold_full <= 1'b1;
        end
      end else if (hold_clear) begin
        hold_full <= 1'b0;
      end

      case (o_state)
        O_IDLE: begin
          if (hold_full && rfd) begin
            data    <= hold;
            dav_    <= 1'b0;
            o_state <= O_DAV;
          end
        end
        O_DAV: begin
          if (!rfd) begin
            dav_    <= 1'b1;
            o_state <= O_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_decoder.sv
// Self-checking bench: directed word table, hand-written handshake/overrun/reset
// sequences, and random pulse trains scored against a width-list model.
module tb_pulse_decoder;

  localparam int SHORT_LEN = 6;
  localparam int LONG_LEN  = 12;
  localparam int TOL       = 1;
  localparam int CNT_MAX   = 31;

  logic       clock = 1'b0;
  logic       reset;
  logic       in;
  logic       rfd;
  logic       dav_;
  logic [7:0] data;
  logic       err;
  logic       ovr;

  pulse_decoder u_dut (
    .clock(clock),
    .reset(reset),
    .in   (in),
    .rfd  (rfd),
    .dav_ (dav_),
    .data (data),
    .err  (err),
    .ovr  (ovr)
  );

  always #5 clock = ~clock;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         err_seen = 0;
  int         last_fall_cyc = 0;
  int         dav_fall_cyc = -1;
  logic       prev_dav = 1'b1;
  logic       auto_ack = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // Word-level reference model state
  int         m_bits = 0;
  logic [7:0] m_word = '0;
  int         m_errs = 0;

  typedef struct {
    int         n;
    int         w[12];
    logic [7:0] exp_word;
    int         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (err === 1'b1) err_seen++;
    if (prev_dav === 1'b1 && dav_ === 1'b0) begin
      dav_fall_cyc = cyc;
      got_q.push_back(data);
    end
    prev_dav = dav_;
    if (auto_ack) rfd = dav_;
  endtask

  // 0 = short bit, 1 = long bit, 2 = invalid width
  function automatic int classify(input int w);
    int c;
    c = (w > CNT_MAX) ? CNT_MAX : w;
    if (c >= SHORT_LEN - TOL && c <= SHORT_LEN + TOL) return 0;
    if (c >= LONG_LEN - TOL && c <= LONG_LEN + TOL) return 1;
    return 2;
  endfunction

  task automatic model_push(input int w);
    int c;
    c = classify(w);
    if (c == 2) begin
      m_errs++;
      m_bits = 0;
      m_word = '0;
    end else begin
      m_word = {m_word[6:0], c[0]};
      m_bits++;
      if (m_bits == 8) begin
        exp_q.push_back(m_word);
        m_bits = 0;
      end
    end
  endtask

  // Drive a pulse of w high samples followed by gap low samples (gap >= 1).
  // fall_rfd >= 0 forces rfd to that value on the falling-edge sample.
  task automatic send_pulse(input int w, input int gap, input int fall_rfd);
    in = 1'b1;
    repeat (w) step();
    in = 1'b0;
    if (fall_rfd >= 0) rfd = fall_rfd[0];
    step();
    last_fall_cyc = cyc;
    check($sformatf("err_at_fall_w%0d", w), {31'd0, err}, {31'd0, classify(w) == 2});
    repeat (gap - 1) step();
  endtask

  task automatic send_word(input logic [7:0] wd);
    for (int b = 7; b >= 0; b--) send_pulse(wd[b] ? LONG_LEN : SHORT_LEN, 3, -1);
  endtask

  initial begin
    vecs[0].n = 8;  vecs[0].w = '{6, 12, 6, 6, 12, 12, 6, 12, 0, 0, 0, 0};
    vecs[0].exp_word = 8'h4D; vecs[0].exp_err = 0;
    vecs[1].n = 8;  vecs[1].w = '{5, 7, 11, 13, 5, 7, 11, 13, 0, 0, 0, 0};
    vecs[1].exp_word = 8'h33; vecs[1].exp_err = 0;
    vecs[2].n = 12; vecs[2].w = '{12, 6, 12, 9, 12, 12, 12, 12, 12, 12, 12, 12};
    vecs[2].exp_word = 8'hFF; vecs[2].exp_err = 1;
    vecs[3].n = 8;  vecs[3].w = '{12, 5, 6, 7, 13, 6, 11, 5, 0, 0, 0, 0};
    vecs[3].exp_word = 8'h8A; vecs[3].exp_err = 0;
    vecs[4].n = 10; vecs[4].w = '{4, 8, 6, 6, 6, 6, 6, 6, 6, 6, 0, 0};
    vecs[4].exp_word = 8'h00; vecs[4].exp_err = 2;
    vecs[5].n = 10; vecs[5].w = '{10, 14, 12, 6, 12, 6, 12, 6, 12, 6, 0, 0};
    vecs[5].exp_word = 8'hAA; vecs[5].exp_err = 2;

    reset = 1'b1; in = 1'b0; rfd = 1'b1;
    step(); step();
    check("rst_dav_", {31'd0, dav_}, 32'd1);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ovr", {31'd0, ovr}, 32'd0);
    reset = 1'b0;
    step();

    // Directed word table, consumer acknowledges automatically
    auto_ack = 1'b1;
    foreach (vecs[i]) begin
      err_seen = 0;
      got_q.delete();
      for (int j = 0; j < vecs[i].n; j++) send_pulse(vecs[i].w[j], 3, -1);
      repeat (3) step();
      check($sformatf("vec%0d_count", i), got_q.size(), 32'd1);
      if (got_q.size() > 0) check($sformatf("vec%0d_word", i), {24'd0, got_q[0]}, {24'd0, vecs[i].exp_word});
      check($sformatf("vec%0d_latency", i), dav_fall_cyc, last_fall_cyc + 1);
      check($sformatf("vec%0d_errs", i), err_seen, vecs[i].exp_err);
      check($sformatf("vec%0d_dav_idle", i), {31'd0, dav_}, 32'd1);
    end

    // Saturation: 40 high clocks pins the counter at its maximum
    in = 1'b1;
    repeat (40) step();
    check("sat_cnt", {27'd0, u_dut.u_meter.cnt}, CNT_MAX);
    in = 1'b0;
    step();
    check("sat_err", {31'd0, err}, 32'd1);
    step();
    check("sat_err_one_cycle", {31'd0, err}, 32'd0);
    repeat (2) step();

    // Word completing on the same edge that empties the hold
    auto_ack = 1'b0; rfd = 1'b1;
    send_word(8'h4D);
    check("sim_first_dav", {31'd0, dav_}, 32'd0);
    check("sim_first_data", {24'd0, data}, 32'h4D);
    for (int b = 7; b >= 1; b--) send_pulse(8'hB2 >> b & 1 ? LONG_LEN : SHORT_LEN, 3, -1);
    send_pulse(SHORT_LEN, 1, 0);
    check("sim_no_ovr", {31'd0, ovr}, 32'd0);
    check("sim_dav_rise", {31'd0, dav_}, 32'd1);
    rfd = 1'b1;
    step();
    check("sim_second_dav", {31'd0, dav_}, 32'd0);
    check("sim_second_data", {24'd0, data}, 32'hB2);
    rfd = 1'b0;
    step();
    rfd = 1'b1;
    repeat (3) step();
    check("sim_hold_empty", {31'd0, dav_}, 32'd1);

    // Overrun: consumer not ready while two words arrive
    rfd = 1'b0;
    send_word(8'h4D);
    check("ovr_waiting", {31'd0, dav_}, 32'd1);
    check("ovr_before", {31'd0, ovr}, 32'd0);
    send_word(8'h33);
    check("ovr_set", {31'd0, ovr}, 32'd1);
    rfd = 1'b1;
    step();
    check("ovr_deliver_dav", {31'd0, dav_}, 32'd0);
    check("ovr_deliver_data", {24'd0, data}, 32'h4D);
    rfd = 1'b0;
    step();
    rfd = 1'b1;
    repeat (3) step();
    check("ovr_second_lost", {31'd0, dav_}, 32'd1);
    check("ovr_sticky", {31'd0, ovr}, 32'd1);

    // Reset in the middle of pulse 4
    auto_ack = 1'b1;
    send_pulse(12, 3, -1); send_pulse(6, 3, -1); send_pulse(12, 3, -1);
    in = 1'b1;
    repeat (4) step();
    reset = 1'b1; in = 1'b0;
    step();
    check("rst_mid_dav_", {31'd0, dav_}, 32'd1);
    check("rst_mid_data", {24'd0, data}, 32'd0);
    check("rst_mid_ovr", {31'd0, ovr}, 32'd0);
    reset = 1'b0;
    got_q.delete();
    send_word(8'h4D);
    repeat (3) step();
    check("rst_mid_next_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("rst_mid_next_word", {24'd0, got_q[0]}, 32'h4D);

    // Reset while dav_ is low discards the held word
    auto_ack = 1'b0; rfd = 1'b1;
    send_word(8'hA5);
    check("rst_dav_low_pre", {31'd0, dav_}, 32'd0);
    check("rst_dav_low_data", {24'd0, data}, 32'hA5);
    reset = 1'b1;
    step();
    check("rst_dav_low_dav_", {31'd0, dav_}, 32'd1);
    check("rst_dav_low_zero", {24'd0, data}, 32'd0);
    reset = 1'b0;
    repeat (3) step();
    check("rst_dav_low_discard", {31'd0, dav_}, 32'd1);
    auto_ack = 1'b1;
    got_q.delete();
    send_word(8'h33);
    repeat (3) step();
    check("rst_dav_low_next_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check("rst_dav_low_next_word", {24'd0, got_q[0]}, 32'h33);

    // Random pulse trains against the width-list model
    err_seen = 0;
    got_q.delete();
    exp_q.delete();
    m_bits = 0; m_word = '0; m_errs = 0;
    for (int k = 0; k < 150; k++) begin
      int r, w;
      r = $urandom_range(0, 9);
      if (r < 4)       w = $urandom_range(5, 7);
      else if (r < 8)  w = $urandom_range(11, 13);
      else if (r == 8) w = $urandom_range(1, 20);
      else             w = $urandom_range(25, 45);
      model_push(w);
      send_pulse(w, $urandom_range(1, 4), -1);
    end
    repeat (5) step();
    check("rnd_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("rnd_word%0d", k), {24'd0, got_q[k]}, {24'd0, exp_q[k]});
    check("rnd_errs", err_seen, m_errs);
    check("rnd_ovr", {31'd0, ovr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_decoder.md
Name: pulse_decoder

Overview:
- Downstream stage of the two-channel pulse former. It consumes the former's `out` line and measures the width of each high pulse in clocks.
- Each width is classified as a data bit:
  - short pulse (nominal 6 clocks): dataB < dataA, bit 0.
  - long pulse (nominal 12 clocks): dataB >= dataA, bit 1.
- Bits are packed MSB-first into a byte, and the byte is handed to a downstream consumer over the codebase's dav_/rfd handshake.

Parameters:
- SHORT_LEN, 6, nominal short-pulse width in clocks.
- LONG_LEN, 12, nominal long-pulse width in clocks.
- TOL, 1, accepted ± deviation in clocks around each nominal width.
- CNT_W, 5, width-counter bits; the counter saturates at 2^CNT_W-1.
- BITS, 8, pulses per output word.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- in  in  1  pulse line from the pulse former, same clock domain, no synchronizer.
- rfd  in  1  consumer ready-for-data.
- dav_  out  1  data valid, active low.
- data  out  BITS  decoded word, stable while dav_=0.
- err  out  1  one-cycle pulse when a pulse width is invalid.
- ovr  out  1  sticky overrun flag; cleared only by reset.

Behaviour:
- Reset (reset=1 at posedge), all outputs and state:
  - dav_=1, data=0, err=0, ovr=0.
  - Width counter=0, bit counter=0, shift register=0, hold-full=0.
  - Both FSMs return to their idle states.
  - Reset mid-pulse or mid-handshake aborts the operation; the partial byte and any held byte are discarded.
- Width FSM:
  - LOW: wait for in=1.
  - When in=1 is sampled: go to HIGH with cnt=1.
  - HIGH, each posedge with in=1: cnt <= cnt+1, saturating at 2^CNT_W-1.
  - HIGH, first posedge with in=0: classify cnt, then return to LOW.
  - Measured width = number of consecutive posedges that sample in=1.
- Classification, performed on the falling-edge cycle:
  - |cnt-SHORT_LEN| <= TOL: shift in 0.
  - |cnt-LONG_LEN| <= TOL: shift in 1.
  - Otherwise, including a saturated count:
    - err=1 for exactly that cycle.
    - Shift register and bit counter are cleared (resynchronise on the next word).
    - ovr is unchanged.
- Packing:
  - First valid pulse becomes data[BITS-1]; shift left.
  - On the BITS-th valid bit the assembled word is copied to the hold register on the same edge, hold-full=1, and the bit counter wraps to 0.
- Output FSM (producer side of dav_/rfd):
  - O_IDLE: dav_=1. If hold-full=1 and rfd=1, drive data from hold and go to O_DAV (dav_ falls on that edge).
  - O_DAV: dav_=0, data held stable. When rfd=0 is sampled: dav_=1, hold-full=0, go to O_IDLE.
  - The next transfer waits for rfd to return to 1.
  - Minimum latency: dav_ falls one edge after the word completes, given rfd=1.
- Simultaneous events and overrun:
  - Word completes on the same edge that clears hold-full (O_DAV with rfd=0): the new word is loaded, hold-full stays 1, no overrun.
  - Word completes while hold-full=1 and the hold is not being cleared: the new word is dropped, ovr=1, the held word is preserved.
- Classification and packing arithmetic are unsigned over CNT_W bits; the compare thresholds are computed at elaboration time.

Decomposition:
- Package pulse_decoder_pkg holds:
  - the width FSM encoding, W_LOW / W_HIGH;
  - the output FSM encoding, O_IDLE / O_DAV;
  - the bit-code constants, BIT_SHORT=0 / BIT_LONG=1.
- One sub-module, pulse_width_meter, owns:
  - the width FSM, saturating counter and classification;
  - its outputs: bit_valid, bit_value, bit_err (single-cycle strobes).
- The top level holds the shift register, bit counter, hold register and output FSM.

Test Plan:
- Basic word:
  - Stimulus: rfd held 1; pulses of widths 6,12,6,6,12,12,6,12 separated by 3 low clocks.
  - Response: dav_ falls 1 edge after the last falling edge with data=0x4D; rfd drop then raises dav_.
- Tolerance:
  - Stimulus: widths 5,7,11,13 repeated twice.
  - Response: data=0x33, err never asserted.
- Bad width:
  - Stimulus: three valid pulses, then width 9, then eight pulses of width 12.
  - Response: err pulses once at the width-9 falling edge; the next word is 0xFF with no leftover bits.
- Saturation:
  - Stimulus: in held high 40 clocks.
  - Response: cnt sticks at 31 and err pulses on the fall.
- Overrun:
  - Stimulus: rfd held 0 after the first word reaches the hold register (dav_ waits in O_IDLE); then a second full word.
  - Response: ovr=1; when rfd rises the first word is delivered and the second is lost.
- Reset:
  - Stimulus: reset asserted in the middle of pulse 4, and separately while dav_=0.
  - Response: next edge gives dav_=1, data=0, ovr=0; the following word decodes correctly from bit 7.
